pcie_us_msi_ctrl: RTL and testbench

PCIE_US_MSI_CTRL -- requirements
Module: pcie_us_msi_ctrl

---
 rtl/pcie_us_msi_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pcie_us_msi_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_us_msi_ctrl.sv
// MSI request controller for the UltraScale PCIe hard block: collects per-vector
// requests into a sticky pending set and issues them one at a time with retry.
module pcie_us_msi_ctrl #(
    parameter int MSI_COUNT   = 32,
    parameter int RETRY_DELAY = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MSI_COUNT-1:0] msi_irq,
    input  logic [3:0]           cfg_interrupt_msi_enable,
    input  logic [11:0]          cfg_interrupt_msi_mmenable,
    output logic [31:0]          cfg_interrupt_msi_int,
    input  logic                 cfg_interrupt_msi_sent,
    input  logic                 cfg_interrupt_msi_fail,
    output logic [3:0]           cfg_interrupt_msi_select,
    output logic [31:0]          cfg_interrupt_msi_pending_status,
    output logic                 cfg_interrupt_msi_pending_status_data_enable,
    output logic [3:0]           cfg_interrupt_msi_pending_status_function_num,
    output logic [2:0]           cfg_interrupt_msi_attr,
    output logic                 cfg_interrupt_msi_tph_present,
    output logic [1:0]           cfg_interrupt_msi_tph_type,
    output logic [8:0]           cfg_interrupt_msi_tph_st_tag,
    output logic [3:0]           cfg_interrupt_msi_function_number,
    output logic                 stat_sent,
    output logic                 stat_fail,
    output logic                 stat_timeout
);

    localparam int CW = $clog2(TIMEOUT + RETRY_DELAY + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [5:0] pick_lowest(input logic [MSI_COUNT-1:0] vec);
        logic [5:0] r;
        r = 6'd0;
        for (int i = MSI_COUNT - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r = {1'b1, 5'(i)};
            end
        end
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [MSI_COUNT-1:0]   pending_q, pending_d;
    logic [4:0]             cur_q, cur_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [31:0]            msi_int_q, msi_int_d;
    logic                   sent_q, sent_d;
    logic                   fail_q, fail_d;
    logic                   timeout_q, timeout_d;
    logic [2:0]             mm_s;
    logic [5:0]             allowed_s;
    logic [MSI_COUNT-1:0]   elig_s;
    logic [MSI_COUNT-1:0]   clr_s;
    logic [5:0]             pick_s;
    logic [31:0]            pending_ext_s;
    logic                   unused_s;

    assign unused_s = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

    // Eligibility: pending, inside the allocated vector range, and MSI enabled.
    always_comb begin
        if (cfg_interrupt_msi_mmenable[2:0] > 3'd5) begin
            mm_s = 3'd5;
        end else begin
            mm_s = cfg_interrupt_msi_mmenable[2:0];
        end
        allowed_s = 6'd1 << mm_s;
        for (int i = 0; i < MSI_COUNT; i++) begin
            elig_s[i] = pending_q[i] & (6'(i) < allowed_s) & cfg_interrupt_msi_enable[0];
        end
        pick_s = pick_lowest(elig_s);
    end

    // Next-state, pending update and registered-output precompute.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        msi_int_d = 32'd0;
        sent_d    = 1'b0;
        fail_d    = 1'b0;
        timeout_d = 1'b0;
        clr_s     = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[5]) begin
                    cur_d     = pick_s[4:0];
                    msi_int_d = 32'd1 << pick_s[4:0];
                    state_d   = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Sent wins over a simultaneous fail.
                if (cfg_interrupt_msi_sent) begin
                    for (int i = 0; i < MSI_COUNT; i++) begin
                        clr_s[i] = (cur_q == 5'(i));
                    end
                    sent_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cfg_interrupt_msi_fail) begin
                    fail_d  = 1'b1;
                    cnt_d   = CW'(RETRY_DELAY);
                    state_d = ST_HOLDOFF;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    cnt_d     = CW'(RETRY_DELAY);
                    state_d   = ST_HOLDOFF;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A new request in the completion cycle keeps the bit set.
        pending_d = (pending_q & ~clr_s) | msi_irq;
    end

    // State, pending set and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            cur_q     <= 5'd0;
            cnt_q     <= '0;
            msi_int_q <= 32'd0;
            sent_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            msi_int_q <= msi_int_d;
            sent_q    <= sent_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    // Zero-extend the pending set to the core's 32-bit status port.
    always_comb begin
        pending_ext_s                  = 32'd0;
        pending_ext_s[MSI_COUNT-1:0]   = pending_q;
    end

    assign cfg_interrupt_msi_int                         = msi_int_q;
    assign cfg_interrupt_msi_pending_status              = pending_ext_s;
    assign cfg_interrupt_msi_select                      = 4'd0;
    assign cfg_interrupt_msi_pending_status_data_enable  = 1'b0;
    assign cfg_interrupt_msi_pending_status_function_num = 4'd0;
    assign cfg_interrupt_msi_attr                        = 3'd0;
    assign cfg_interrupt_msi_tph_present                 = 1'b0;
    assign cfg_interrupt_msi_tph_type                    = 2'd0;
    assign cfg_interrupt_msi_tph_st_tag                  = 9'd0;
    assign cfg_interrupt_msi_function_number             = 4'd0;
    assign stat_sent                                     = sent_q;
    assign stat_fail                                     = fail_q;
    assign stat_timeout                                  = timeout_q;

endmodule

// File: tb/tb_pcie_us_msi_ctrl.sv
// Scenario bench for pcie_us_msi_ctrl: expected MSI strobes are queued when
// requests are driven and popped by a monitor whenever the DUT strobes.
module tb_pcie_us_msi_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] msi_irq;
    logic [3:0]  msi_enable;
    logic [11:0] msi_mmenable;
    logic [31:0] msi_int;
    logic        msi_sent;
    logic        msi_fail;
    logic [3:0]  sel;
    logic [31:0] pend;
    logic        pend_de;
    logic [3:0]  pend_fn;
    logic [2:0]  attr;
    logic        tph_p;
    logic [1:0]  tph_t;
    logic [8:0]  tph_tag;
    logic [3:0]  fn;
    logic        st_sent, st_fail, st_to;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int int_count = 0, int_cyc = 0;
    int sent_cnt = 0, fail_cnt = 0, to_cnt = 0, to_cyc = 0;
    logic [31:0] exp_q[$];

    pcie_us_msi_ctrl #(.MSI_COUNT(32), .RETRY_DELAY(16), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .msi_irq(msi_irq),
        .cfg_interrupt_msi_enable(msi_enable),
        .cfg_interrupt_msi_mmenable(msi_mmenable),
        .cfg_interrupt_msi_int(msi_int),
        .cfg_interrupt_msi_sent(msi_sent),
        .cfg_interrupt_msi_fail(msi_fail),
        .cfg_interrupt_msi_select(sel),
        .cfg_interrupt_msi_pending_status(pend),
        .cfg_interrupt_msi_pending_status_data_enable(pend_de),
        .cfg_interrupt_msi_pending_status_function_num(pend_fn),
        .cfg_interrupt_msi_attr(attr),
        .cfg_interrupt_msi_tph_present(tph_p),
        .cfg_interrupt_msi_tph_type(tph_t),
        .cfg_interrupt_msi_tph_st_tag(tph_tag),
        .cfg_interrupt_msi_function_number(fn),
        .stat_sent(st_sent), .stat_fail(st_fail), .stat_timeout(st_to)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (msi_int !== 32'd0) begin
            checks++;
            int_count++;
            int_cyc = cyc;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_msi_int: got %08h, expected none", msi_int);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (msi_int !== e) begin
                    errors++;
                    $display("FAIL msi_int_value: got %08h, expected %08h", msi_int, e);
                end
            end
        end
        if (st_sent === 1'b1) sent_cnt++;
        if (st_fail === 1'b1) fail_cnt++;
        if (st_to === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq(input logic [31:0] v, output int c);
        @(posedge clk); #1;
        msi_irq = v;
        c = cyc;
        @(posedge clk); #1;
        msi_irq = 32'd0;
    endtask

    task automatic respond(input logic s, input logic f, input logic [31:0] irq, output int c);
        @(posedge clk); #1;
        msi_sent = s;
        msi_fail = f;
        msi_irq = irq;
        c = cyc;
        @(posedge clk); #1;
        msi_sent = 1'b0;
        msi_fail = 1'b0;
        msi_irq = 32'd0;
    endtask

    task automatic wait_int(input int bound, input string name);
        int start;
        bit got;
        start = int_count;
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (int_count > start) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_wait: no msi_int within %0d cycles, expected one", name, bound);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        msi_irq = 32'hFFFF_FFFF;
        msi_sent = 1'b1;
        tick(3);
        msi_irq = 32'd0;
        msi_sent = 1'b0;
        @(negedge clk);
        checks++;
        if ({msi_int, pend, st_sent, st_fail, st_to} !== 67'd0) begin
            errors++;
            $display("FAIL reset_outputs: got int=%08h pend=%08h stats=%b%b%b, expected all 0",
                     msi_int, pend, st_sent, st_fail, st_to);
        end
        checks++;
        if ({sel, pend_de, pend_fn, attr, tph_p, tph_t, tph_tag, fn} !== 28'd0) begin
            errors++;
            $display("FAIL const_outputs: got nonzero constant port, expected 0");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single();
        int c, s0, rc;
        s0 = sent_cnt;
        exp_q.push_back(32'h8);
        pulse_irq(32'h8, c);
        wait_int(10, "single");
        checks++;
        if (int_cyc != c + 2) begin
            errors++;
            $display("FAIL single_latency: got cycle %0d, expected %0d", int_cyc, c + 2);
        end
        tick(4);
        respond(1'b1, 1'b0, 32'd0, rc);
        tick(2);
        checks++;
        if (pend !== 32'd0 || sent_cnt != s0 + 1) begin
            errors++;
            $display("FAIL single_done: got pend=%08h sent=%0d, expected 0 and %0d",
                     pend, sent_cnt - s0, 1);
        end
    endtask

    task automatic test_two();
        int c, s0, rc;
        s0 = sent_cnt;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h80);
        pulse_irq(32'h84, c);
        wait_int(10, "two_a");
        respond(1'b1, 1'b0, 32'd0, rc);
        wait_int(10, "two_b");
        checks++;
        if (int_cyc < rc + 2) begin
            errors++;
            $display("FAIL two_gap: got second send at %0d, expected >= %0d", int_cyc, rc + 2);
        end
        respond(1'b1, 1'b0, 32'd0, rc);
        tick(2);
        checks++;
        if (pend !== 32'd0 || sent_cnt != s0 + 2) begin
            errors++;
            $display("FAIL two_done: got pend=%08h sent=%0d, expected 0 and 2", pend, sent_cnt - s0);
        end
    endtask

    task automatic test_masked();
        int c, n0, rc;
        msi_mmenable = 12'd1;
        n0 = int_count;
        pulse_irq(32'h20, c);
        tick(10);
        checks++;
        if (int_count != n0 || pend !== 32'h20) begin
            errors++;
            $display("FAIL masked_hold: got ints=%0d pend=%08h, expected 0 and 00000020",
                     int_count - n0, pend);
        end
        exp_q.push_back(32'h20);
        msi_mmenable = 12'd3;
        c = cyc;
        wait_int(10, "masked");
        checks++;
        if (int_cyc > c + 2) begin
            errors++;
            $display("FAIL masked_latency: got cycle %0d, expected <= %0d", int_cyc, c + 2);
        end
        respond(1'b1, 1'b0, 32'd0, rc);
        msi_mmenable = 12'd5;
        tick(2);
    endtask

    task automatic test_fail_retry();
        int c, f0, fc, rc;
        f0 = fail_cnt;
        exp_q.push_back(32'h1);
        pulse_irq(32'h1, c);
        wait_int(10, "fail_first");
        exp_q.push_back(32'h1);
        respond(1'b0, 1'b1, 32'd0, fc);
        tick(3);
        checks++;
        if (fail_cnt != f0 + 1 || pend !== 32'h1) begin
            errors++;
            $display("FAIL fail_status: got fails=%0d pend=%08h, expected 1 and 00000001",
                     fail_cnt - f0, pend);
        end
        wait_int(40, "fail_retry");
        checks++;
        if (int_cyc - fc < 17 || int_cyc - fc > 18) begin
            errors++;
            $display("FAIL fail_retry_delay: got %0d cycles, expected 17..18", int_cyc - fc);
        end
        respond(1'b1, 1'b0, 32'd0, rc);
        tick(2);
        checks++;
        if (pend !== 32'd0) begin
            errors++;
            $display("FAIL fail_cleared: got pend=%08h, expected 0", pend);
        end
    endtask

    task automatic test_back_to_back();
        int c, s0, f0, rc;
        s0 = sent_cnt;
        f0 = fail_cnt;
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h10);
        pulse_irq(32'h10, c);
        wait_int(10, "b2b_a");
        respond(1'b1, 1'b1, 32'h10, rc);
        tick(1);
        checks++;
        if (pend !== 32'h10) begin
            errors++;
            $display("FAIL set_beats_clear: got pend=%08h, expected 00000010", pend);
        end
        wait_int(10, "b2b_b");
        msi_enable = 4'd0;
        respond(1'b1, 1'b0, 32'd0, rc);
        tick(2);
        checks++;
        if (sent_cnt != s0 + 2 || fail_cnt != f0 || pend !== 32'd0) begin
            errors++;
            $display("FAIL b2b_stats: got sent=%0d fail=%0d pend=%08h, expected 2 0 00000000",
                     sent_cnt - s0, fail_cnt - f0, pend);
        end
        msi_enable = 4'd1;
    endtask

    task automatic test_timeout_reset();
        int c, s_cyc, t0, s0, rc;
        bit got;
        t0 = to_cnt;
        exp_q.push_back(32'h2);
        pulse_irq(32'h2, c);
        wait_int(10, "to_first");
        s_cyc = int_cyc;
        got = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            if (to_cnt > t0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        checks++;
        if (!got || to_cyc - s_cyc < 1024 || to_cyc - s_cyc > 1025) begin
            errors++;
            $display("FAIL timeout_delay: got seen=%0d after %0d cycles, expected 1 after 1024..1025",
                     got, to_cyc - s_cyc);
        end
        exp_q.push_back(32'h2);
        wait_int(40, "to_retry");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({msi_int, pend, st_sent, st_fail, st_to} !== 67'd0) begin
            errors++;
            $display("FAIL reset_in_wait: got int=%08h pend=%08h, expected all 0", msi_int, pend);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        s0 = sent_cnt;
        respond(1'b1, 1'b0, 32'd0, rc);
        tick(6);
        checks++;
        if (sent_cnt != s0 || pend !== 32'd0) begin
            errors++;
            $display("FAIL late_sent: got sent=%0d pend=%08h, expected 0 and 0", sent_cnt - s0, pend);
        end
    endtask

    initial begin
        msi_irq = 32'd0;
        msi_sent = 1'b0;
        msi_fail = 1'b0;
        msi_enable = 4'd1;
        msi_mmenable = 12'd5;
        test_reset();
        test_single();
        test_two();
        test_masked();
        test_fail_retry();
        test_back_to_back();
        test_timeout_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
